mem_req_unit: RTL and testbench
===============================

MEM_REQ_UNIT -- requirements
Module: mem_req_unit

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: ex_valid in 1, ex_op in 4 (mem_op_t), ex_base in 32, ex_offset in 32 (pre-sign-extended), ex_wdata in 32, ex_ready out 1: issue handshake.
REQ-004 SHALL have: flush  in  1  squash in-flight op.
REQ-005 SHALL have to mmu data port: req out 1, va out 32, we out 1, size out 2, wstrb out 4, wdata out 32, cancel out 1.
REQ-006 SHALL have from mmu data port: addr_ok, data_ok in 1; rdata in 32; tlbr, pil, pis, ppi, pme in 1 each.
REQ-007 SHALL have to writeback: wb_valid out 1, wb_rdata out 32, wb_have_excp out 1, wb_excp_type out excp_t, wb_badv out 32, wb_ready in 1.

Function
REQ-008 SHALL implement FSM IDLE, REQ, WAIT, DONE, DRAIN; ex_ready = (state==IDLE) && !flush.
REQ-009 SHALL, on ex_valid && ex_ready, latch op, va = ex_base + ex_offset (32-bit, wrap modulo 2^32), wdata; next state REQ, or DONE with ALE if misaligned.
REQ-010 SHALL flag ALE when half op and va[0]!=0, or word op and va[1:0]!=0; no mmu request issued for ALE.
REQ-011 SHALL drive size 0/1/2 for byte/half/word; wstrb = 4'b0001<<va[1:0] (byte), 4'b0011<<va[1:0] (half), 4'b1111 (word); wstrb = 0 for loads.
REQ-012 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-013 SHALL assert req = (state==REQ) && !flush, with va/we/size/wstrb/wdata stable while req is high.
REQ-014 SHALL, in REQ, if any of tlbr/pil/pis/ppi/pme is high: assert cancel that cycle, ignore addr_ok, go to DONE with exception.
REQ-015 SHALL prioritise exceptions ALE > TLBR > PIL/PIS > PPI > PME; wb_badv = latched va whenever wb_have_excp.
REQ-016 SHALL, in REQ with addr_ok and no exception, go to WAIT; data_ok is ignored in REQ.
REQ-017 SHALL, in WAIT on data_ok, register load result and go to DONE; store result = 0.
REQ-018 SHALL form load result: rdata >> (8*va[1:0]), then sign-extend (LD_B/LD_H) or zero-extend (LD_BU/LD_HU); LD_W unchanged.
REQ-019 SHALL assert wb_valid only in DONE; hold all wb_* stable until wb_valid && wb_ready, then IDLE.
REQ-020 SHALL handle flush: REQ -> IDLE, cancel high, req low same cycle; WAIT -> DRAIN; DONE -> IDLE, result dropped; IDLE -> no op accepted.
REQ-021 SHALL, in DRAIN, keep wb_valid low and go to IDLE on data_ok; further flush in DRAIN has no effect.
REQ-022 SHALL, when flush coincides with data_ok in WAIT, go directly to IDLE.
REQ-023 SHALL accept at most one outstanding mmu request; next op issue no earlier than cycle after DONE/DRAIN exit.

Reset
REQ-024 SHALL, while reset low at a clock edge, enter IDLE; outputs req=0, cancel=0, wb_valid=0, wb_have_excp=0, wb_rdata=0, wb_badv=0, ex_ready=0 during reset.
REQ-025 SHALL drop any outstanding request on reset without draining; a data_ok after reset release in IDLE is ignored.

Structure
REQ-026 SHALL take mem_op_t (LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W), excp_t (includes ALE, TLBR, PIL, PIS, PPI, PME) and the FSM state enum from the shared definitions package.
REQ-027 SHALL place load shift/extend and store wstrb/wdata formation in one combinational sub-module mem_align.

Verification
REQ-028 SHALL test: LD_B base 0x1000_0003 off 0, rdata 0x80FF_FFFF, addr_ok cycle 2, data_ok cycle 3 -> size 0, wb_rdata 0xFFFF_FF80, wb_valid cycle 4.
REQ-029 SHALL test: ST_H base 0x2000, off 2, wdata 0x1234_ABCD -> wstrb 4'b1100, wdata 0xABCD_ABCD, we=1, wb_rdata 0.
REQ-030 SHALL test: LD_W va 0x0000_1002 -> no req, wb_have_excp=1, ALE, wb_badv 0x0000_1002.
REQ-031 SHALL test: LD_HU with tlbr=1 and pil=1 in REQ -> cancel=1 that cycle, excp TLBR, no wait for data_ok.
REQ-032 SHALL test: flush in WAIT, data_ok 3 cycles later -> DRAIN, wb_valid never high, ex_ready high the cycle after data_ok.
REQ-033 SHALL test: wb_ready low 5 cycles in DONE -> wb_* stable; reset low mid-WAIT -> IDLE, req=0, next op completes normally.

Source files
------------

// File: rtl/mem_req_unit_pkg.sv
// mem_req_unit_pkg: shared op, exception and FSM state types plus op decode helpers
package mem_req_unit_pkg;
    typedef enum logic [3:0] {LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W} mem_op_t;
    typedef enum logic [2:0] {EXCP_NONE, ALE, TLBR, PIL, PIS, PPI, PME} excp_t;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    function automatic logic [1:0] op_size(input mem_op_t op);
        return (op == LD_B || op == LD_BU || op == ST_B) ? 2'd0 :
               (op == LD_H || op == LD_HU || op == ST_H) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic op_store(input mem_op_t op);
        return op inside {ST_B, ST_H, ST_W};
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] lo);
        return (op_size(op) == 2'd1 && lo[0]) || (op_size(op) == 2'd2 && lo != 2'd0);
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane strobes/replication and load shift/extend
module mem_align
    import mem_req_unit_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic [31:0] sh;

    always_comb begin
        sh = rdata >> {off, 3'b000};
        size = op_size(op);
        wstrb = !op_store(op) ? 4'b0000 : size == 2'd0 ? 4'b0001 << off :
                size == 2'd1 ? 4'b0011 << off : 4'b1111;
        wdata = size == 2'd0 ? {4{st_data[7:0]}} : size == 2'd1 ? {2{st_data[15:0]}} : st_data;
        ldata = op == LD_B  ? {{24{sh[7]}}, sh[7:0]} :
                op == LD_BU ? {24'b0, sh[7:0]} :
                op == LD_H  ? {{16{sh[15]}}, sh[15:0]} :
                op == LD_HU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/mem_req_unit.sv
// mem_req_unit: single-outstanding load/store issue to the mmu data port with exception capture
module mem_req_unit
    import mem_req_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  mem_op_t     ex_op,
    input  logic [31:0] ex_base,
    input  logic [31:0] ex_offset,
    input  logic [31:0] ex_wdata,
    output logic        ex_ready,
    input  logic        flush,
    output logic        req,
    output logic [31:0] va,
    output logic        we,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        cancel,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    input  logic        tlbr,
    input  logic        pil,
    input  logic        pis,
    input  logic        ppi,
    input  logic        pme,
    output logic        wb_valid,
    output logic [31:0] wb_rdata,
    output logic        wb_have_excp,
    output excp_t       wb_excp_type,
    output logic [31:0] wb_badv,
    input  logic        wb_ready
);
    state_t      state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [31:0] va_q, va_d, wdata_q, wdata_d, res_q, res_d, ex_va, ldata;
    logic        exc_q, exc_d, ale;
    excp_t       et_q, et_d, mmu_et;

    assign ex_va = ex_base + ex_offset;
    assign ale = misaligned(ex_op, ex_va[1:0]);
    assign mmu_et = tlbr ? TLBR : pil ? PIL : pis ? PIS : ppi ? PPI : pme ? PME : EXCP_NONE;
    assign ex_ready = reset && state_q == IDLE && !flush;
    assign req = reset && state_q == REQ && !flush;
    assign cancel = reset && state_q == REQ && (flush || mmu_et != EXCP_NONE);
    assign va = va_q;
    assign we = op_store(op_q);
    assign wb_valid = reset && state_q == DONE;
    assign wb_rdata = reset ? res_q : '0;
    assign wb_have_excp = reset && exc_q;
    assign wb_excp_type = et_q;
    assign wb_badv = wb_have_excp ? va_q : '0;

    mem_align u_align (
        .op      (op_q),
        .off     (va_q[1:0]),
        .st_data (wdata_q),
        .rdata   (rdata),
        .size    (size),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .ldata   (ldata)
    );

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        va_d = va_q;
        wdata_d = wdata_q;
        res_d = res_q;
        exc_d = exc_q;
        et_d = et_q;
        case (state_q)
            IDLE: if (ex_valid && ex_ready) begin
                op_d = ex_op;
                va_d = ex_va;
                wdata_d = ex_wdata;
                res_d = '0;
                exc_d = ale;
                et_d = ale ? ALE : EXCP_NONE;
                state_d = ale ? DONE : REQ;
            end
            REQ: if (flush) state_d = IDLE;
                 else if (mmu_et != EXCP_NONE) begin
                     exc_d = 1'b1;
                     et_d = mmu_et;
                     state_d = DONE;
                 end else if (addr_ok) state_d = WAIT;
            WAIT: if (data_ok) begin
                res_d = we ? '0 : ldata;
                state_d = flush ? IDLE : DONE;
            end else if (flush) state_d = DRAIN;
            DONE: if (flush || wb_ready) state_d = IDLE;
            DRAIN: if (data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q <= LD_B;
            va_q <= '0;
            wdata_q <= '0;
            res_q <= '0;
            exc_q <= 1'b0;
            et_q <= EXCP_NONE;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            va_q <= va_d;
            wdata_q <= wdata_d;
            res_q <= res_d;
            exc_q <= exc_d;
            et_q <= et_d;
        end
    end
endmodule

// File: tb/tb_mem_req_unit.sv
// tb_mem_req_unit: directed and randomized transactions checked against a byte-level reference model
module tb_mem_req_unit;
    import mem_req_unit_pkg::*;

    logic clk = 1'b0, reset, ex_valid, flush, addr_ok, data_ok, tlbr, pil, pis, ppi, pme, wb_ready;
    mem_op_t ex_op;
    logic [31:0] ex_base, ex_offset, ex_wdata, rdata;
    logic ex_ready, req, we, cancel, wb_valid, wb_have_excp;
    logic [31:0] va, wdata, wb_rdata, wb_badv;
    logic [1:0] size;
    logic [3:0] wstrb;
    excp_t wb_excp_type;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_req_unit dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_base(ex_base),
        .ex_offset(ex_offset), .ex_wdata(ex_wdata), .ex_ready(ex_ready), .flush(flush),
        .req(req), .va(va), .we(we), .size(size), .wstrb(wstrb), .wdata(wdata), .cancel(cancel),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .tlbr(tlbr), .pil(pil), .pis(pis),
        .ppi(ppi), .pme(pme), .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_have_excp(wb_have_excp),
        .wb_excp_type(wb_excp_type), .wb_badv(wb_badv), .wb_ready(wb_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input mem_op_t op);
        return (op == LD_B || op == LD_BU || op == ST_B) ? 1 : (op == LD_H || op == LD_HU || op == ST_H) ? 2 : 4;
    endfunction

    task automatic issue(input mem_op_t op, input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; ex_base = base; ex_offset = off; ex_wdata = wd;
        #1 chk("issue_ready", ex_ready, 1);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic xact(input mem_op_t op, input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wd, input logic [31:0] rd, input int a_lat, input int d_lat,
                        input int hold, input logic [4:0] ex);
        logic [31:0] v, res, ewd;
        logic [3:0] strb;
        int n, lane;
        logic st, ale;
        excp_t et;
        v = base + off;
        n = nbytes(op);
        lane = int'(v % 4);
        st = op inside {ST_B, ST_H, ST_W};
        ale = (v % n) != 0;
        res = 0; strb = 0; ewd = 0;
        if (!ale) for (int k = 0; k < n; k++) begin
            res[8*k +: 8] = rd[8*(lane+k) +: 8];
            if (st) strb[lane+k] = 1'b1;
        end
        if ((op == LD_B || op == LD_H) && res[8*n-1]) res = res | (32'hFFFF_FFFF << (8*n));
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
        et = ale ? ALE : ex[4] ? TLBR : ex[3] ? PIL : ex[2] ? PIS : ex[1] ? PPI : ex[0] ? PME : EXCP_NONE;
        if (st || et != EXCP_NONE) res = 0;
        issue(op, base, off, wd);
        if (!ale) begin
            for (int i = 0; i <= (ex != 0 ? 0 : a_lat); i++) begin
                {tlbr, pil, pis, ppi, pme} = ex;
                addr_ok = (i == a_lat);
                data_ok = 1'($urandom_range(0, 1));
                rdata = $urandom;
                #1;
                chk("req", req, 1);
                chk("va", va, v);
                chk("we", we, st);
                chk("size", size, n == 1 ? 0 : n == 2 ? 1 : 2);
                chk("wstrb", wstrb, strb);
                chk("cancel", cancel, ex != 0);
                if (st) chk("wdata", wdata, ewd);
                @(negedge clk);
            end
            {tlbr, pil, pis, ppi, pme} = 5'b0;
            addr_ok = 1'b0;
            if (ex == 0) for (int i = 0; i <= d_lat; i++) begin
                data_ok = (i == d_lat);
                rdata = data_ok ? rd : $urandom;
                #1;
                chk("wait_req", req, 0);
                chk("wait_wbv", wb_valid, 0);
                @(negedge clk);
            end
            data_ok = 1'b0;
        end
        for (int i = 0; i <= hold; i++) begin
            wb_ready = (i == hold);
            #1;
            chk("wb_valid", wb_valid, 1);
            chk("done_req", req, 0);
            chk("wb_rdata", wb_rdata, res);
            chk("wb_have_excp", wb_have_excp, et != EXCP_NONE);
            chk("wb_excp_type", wb_excp_type, et);
            chk("wb_badv", wb_badv, et != EXCP_NONE ? v : 0);
            @(negedge clk);
        end
        wb_ready = 1'b0;
        #1 chk("back_idle", ex_ready, 1);
    endtask

    initial begin
        reset = 1'b0; ex_valid = 0; flush = 0; addr_ok = 0; data_ok = 0; wb_ready = 0;
        {tlbr, pil, pis, ppi, pme} = 5'b0;
        ex_op = LD_W; ex_base = 0; ex_offset = 0; ex_wdata = 0; rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_cancel", cancel, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_excp", wb_have_excp, 0);
        chk("rst_rdata", wb_rdata, 0);
        chk("rst_badv", wb_badv, 0);
        chk("rst_ready", ex_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("post_rst_ready", ex_ready, 1);

        xact(LD_B, 32'h1000_0003, 32'h0, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 5'b0);
        xact(ST_H, 32'h0000_2000, 32'h2, 32'h1234_ABCD, 32'h5555_5555, 1, 1, 0, 5'b0);
        xact(LD_W, 32'h0000_1000, 32'h2, 32'h0, 32'h0, 0, 0, 1, 5'b0);
        xact(LD_HU, 32'h0000_3000, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 5'b11000);
        xact(LD_W, 32'h0000_4000, 32'h4, 32'h0, 32'hDEAD_BEEF, 2, 3, 5, 5'b0);

        // flush in WAIT, a second flush in DRAIN, data_ok three cycles after the first
        issue(LD_W, 32'h5000, 32'h0, 32'h0);
        addr_ok = 1'b1;
        #1 chk("fw_req", req, 1);
        @(negedge clk);
        addr_ok = 1'b0; flush = 1'b1;
        #1 chk("fw_ready", ex_ready, 0);
        chk("fw_wbv0", wb_valid, 0);
        @(negedge clk);
        #1 chk("fw_wbv1", wb_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fw_drain_ready", ex_ready, 0);
        chk("fw_wbv2", wb_valid, 0);
        @(negedge clk);
        data_ok = 1'b1; rdata = 32'h1234_5678;
        #1 chk("fw_wbv3", wb_valid, 0);
        chk("fw_ready_dok", ex_ready, 0);
        @(negedge clk);
        data_ok = 1'b0;
        #1 chk("fw_ready_after", ex_ready, 1);
        chk("fw_wbv4", wb_valid, 0);

        issue(LD_W, 32'h5100, 32'h0, 32'h0);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0; flush = 1'b1; data_ok = 1'b1;
        @(negedge clk);
        flush = 1'b0; data_ok = 1'b0;
        #1 chk("fdok_ready", ex_ready, 1);
        chk("fdok_wbv", wb_valid, 0);

        issue(ST_W, 32'h5200, 32'h0, 32'hCAFE_F00D);
        flush = 1'b1;
        #1 chk("freq_req", req, 0);
        chk("freq_cancel", cancel, 1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("freq_ready", ex_ready, 1);

        issue(LD_H, 32'h5301, 32'h0, 32'h0);
        flush = 1'b1;
        #1 chk("fdone_wbv", wb_valid, 1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fdone_drop", wb_valid, 0);
        chk("fdone_ready", ex_ready, 1);

        @(negedge clk);
        ex_valid = 1'b1; flush = 1'b1; ex_op = LD_W; ex_base = 32'h5400; ex_offset = 0;
        #1 chk("fidle_ready", ex_ready, 0);
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        #1 chk("fidle_req", req, 0);
        chk("fidle_ready2", ex_ready, 1);

        issue(LD_W, 32'h6000, 32'h0, 32'h0);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0; reset = 1'b0;
        #1 chk("rw_ready", ex_ready, 0);
        @(negedge clk);
        #1 chk("rw_req", req, 0);
        chk("rw_wbv", wb_valid, 0);
        chk("rw_rdata", wb_rdata, 0);
        chk("rw_badv", wb_badv, 0);
        reset = 1'b1; data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        data_ok = 1'b0;
        #1 chk("rw_stray_ready", ex_ready, 1);
        chk("rw_stray_wbv", wb_valid, 0);
        xact(LD_BU, 32'h6000, 32'h1, 32'h0, 32'h0000_9A00, 1, 2, 0, 5'b0);

        repeat (40) begin
            mem_op_t op;
            logic [31:0] base, off;
            op = mem_op_t'($urandom_range(0, 7));
            base = $urandom;
            off = 32'($urandom_range(0, 64));
            if ($urandom_range(0, 1) == 1) begin
                base[1:0] = 2'b00;
                off[1:0] = 2'b00;
            end
            xact(op, base, off, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
